// File: rtl/deserializer.sv
// Serial-to-parallel receiver: collects MSB-first bursts into left-aligned words,
// tagging partial bursts with their bit count and discarding 1..2-bit runts.
module deserializer #(
  parameter int DATA_W     = 16,
  parameter int DATA_MOD_W = 4
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  ser_data_i,
  input  logic                  ser_data_val_i,
  output logic [DATA_W-1:0]     deser_data_o,
  output logic [DATA_MOD_W-1:0] deser_mod_o,
  output logic                  deser_val_o,
  output logic                  runt_o,
  output logic                  busy_o
);

  localparam logic [DATA_MOD_W:0] CNT_LAST = (DATA_MOD_W+1)'(DATA_W - 1);
  localparam logic [DATA_MOD_W:0] CNT_MIN  = (DATA_MOD_W+1)'(3);
  localparam logic [DATA_MOD_W:0] CNT_ONE  = (DATA_MOD_W+1)'(1);

  logic [DATA_MOD_W:0]   r_cnt;
  logic [DATA_W-1:0]     r_sr;
  logic [DATA_W-1:0]     r_data;
  logic [DATA_MOD_W-1:0] r_mod;
  logic                  r_val;
  logic                  r_runt;
  logic                  r_busy;

  logic [DATA_MOD_W-1:0] w_idx;
  logic [DATA_W-1:0]     w_sr_set;

  // With DATA_W == 2**DATA_MOD_W, DATA_W-1-cnt is just the bitwise inverse of cnt.
  always_comb begin
    w_idx           = ~r_cnt[DATA_MOD_W-1:0];
    w_sr_set        = r_sr;
    w_sr_set[w_idx] = ser_data_i;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_cnt  <= '0;
      r_sr   <= '0;
      r_data <= '0;
      r_mod  <= '0;
      r_val  <= 1'b0;
      r_runt <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_val  <= 1'b0;
      r_runt <= 1'b0;
      if (ser_data_val_i) begin
        if (r_cnt == CNT_LAST) begin
          r_data <= w_sr_set;
          r_mod  <= '0;
          r_val  <= 1'b1;
          r_cnt  <= '0;
          r_sr   <= '0;
          r_busy <= 1'b0;
        end else begin
          r_sr   <= w_sr_set;
          r_cnt  <= r_cnt + CNT_ONE;
          r_busy <= 1'b1;
        end
      end else if (r_cnt != '0) begin
        // Burst ended early: emit a partial word or flag a runt.
        if (r_cnt >= CNT_MIN) begin
          r_data <= r_sr;
          r_mod  <= r_cnt[DATA_MOD_W-1:0];
          r_val  <= 1'b1;
        end else begin
          r_runt <= 1'b1;
        end
        r_cnt  <= '0;
        r_sr   <= '0;
        r_busy <= 1'b0;
      end
    end
  end

  assign deser_data_o = r_data;
  assign deser_mod_o  = r_mod;
  assign deser_val_o  = r_val;
  assign runt_o       = r_runt;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer: expected words are queued as bursts are driven
// and compared whenever the DUT issues a deser_val_o pulse.
module tb_deserializer;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        ser_data = 1'b0;
  logic        ser_val = 1'b0;
  logic [15:0] deser_data;
  logic [3:0]  deser_mod;
  logic        deser_val;
  logic        runt;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int runt_cnt = 0;
  int pulse_cnt = 0;
  logic [19:0] exp_q[$];
  int pulse_cyc_q[$];

  deserializer #(.DATA_W(16), .DATA_MOD_W(4)) dut (
    .clk_i(clk),
    .arst_i(arst),
    .ser_data_i(ser_data),
    .ser_data_val_i(ser_val),
    .deser_data_o(deser_data),
    .deser_mod_o(deser_mod),
    .deser_val_o(deser_val),
    .runt_o(runt),
    .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every pulse.
  always @(negedge clk) begin
    if (!arst) begin
      if (runt) runt_cnt++;
      if (deser_val) begin
        logic [19:0] e;
        pulse_cnt++;
        pulse_cyc_q.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse: got data=%h mod=%0d, required no pulse", deser_data, deser_mod);
        end else begin
          e = exp_q.pop_front();
          if ({deser_data, deser_mod} !== e) begin
            failures++;
            $display("FAIL word: got data=%h mod=%0d, required data=%h mod=%0d",
                     deser_data, deser_mod, e[19:4], e[3:0]);
          end
        end
      end
    end
  end

  task automatic send_word(input logic [15:0] w, input int n, input int gap, input bit expect_out);
    logic [15:0] mask;
    logic [3:0]  m;
    mask = ~(16'hFFFF >> n);
    m = n[3:0];
    if (expect_out) exp_q.push_back({w & mask, m});
    for (int i = 0; i < n; i++) begin
      ser_val = 1'b1;
      ser_data = w[15-i];
      @(posedge clk); #1;
    end
    for (int g = 0; g < gap; g++) begin
      ser_val = 1'b0;
      ser_data = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    ser_val = 1'b0;
    ser_data = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    arst = 1'b1;
    idle(2);
    checks++;
    if ({deser_data, deser_mod, deser_val, runt, busy} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs: got data=%h mod=%0d val=%b runt=%b busy=%b, required all 0",
               deser_data, deser_mod, deser_val, runt, busy);
    end
    arst = 1'b0;
    idle(2);
    checks++;
    if (deser_val !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got val=%b busy=%b, required 0 0", deser_val, busy);
    end
  endtask

  task automatic test_full_word;
    send_word(16'hA5C3, 16, 0, 1'b1);
    checks++;
    if (deser_val !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL full_latency: got val=%b busy=%b, required 1 0", deser_val, busy);
    end
    idle(1);
    checks++;
    if (deser_val !== 1'b0 || deser_data !== 16'hA5C3) begin
      failures++;
      $display("FAIL full_hold: got val=%b data=%h, required 0 a5c3", deser_val, deser_data);
    end
    idle(2);
  endtask

  task automatic test_back_to_back;
    pulse_cyc_q.delete();
    send_word(16'h1234, 16, 0, 1'b1);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_busy_between: got busy=%b, required 0", busy);
    end
    send_word(16'hFFFF, 16, 0, 1'b1);
    idle(3);
    checks++;
    if (pulse_cyc_q.size() != 2) begin
      failures++;
      $display("FAIL b2b_pulses: got %0d pulses, required 2", pulse_cyc_q.size());
    end else if (pulse_cyc_q[1] - pulse_cyc_q[0] != 16) begin
      failures++;
      $display("FAIL b2b_spacing: got %0d clk, required 16", pulse_cyc_q[1] - pulse_cyc_q[0]);
    end
  endtask

  task automatic test_partial;
    int r0;
    r0 = runt_cnt;
    send_word(16'hB800, 5, 1, 1'b1);
    checks++;
    if (deser_val !== 1'b1 || deser_data !== 16'hB800 || deser_mod !== 4'd5) begin
      failures++;
      $display("FAIL partial5: got val=%b data=%h mod=%0d, required 1 b800 5",
               deser_val, deser_data, deser_mod);
    end
    send_word(16'hE000, 3, 2, 1'b1);
    send_word(16'h7FFE, 15, 2, 1'b1);
    checks++;
    if (runt_cnt != r0) begin
      failures++;
      $display("FAIL partial_runt: got %0d runts, required 0", runt_cnt - r0);
    end
  endtask

  task automatic test_runt;
    int r0, p0;
    logic [15:0] d0;
    logic [3:0]  m0;
    for (int n = 2; n >= 1; n--) begin
      r0 = runt_cnt; p0 = pulse_cnt; d0 = deser_data; m0 = deser_mod;
      send_word(16'hC000, n, 1, 1'b0);
      checks++;
      if (runt !== 1'b1 || deser_val !== 1'b0) begin
        failures++;
        $display("FAIL runt%0d_pulse: got runt=%b val=%b, required 1 0", n, runt, deser_val);
      end
      idle(2);
      checks++;
      if (runt_cnt != r0 + 1 || pulse_cnt != p0 || deser_data !== d0 || deser_mod !== m0) begin
        failures++;
        $display("FAIL runt%0d_hold: got runts=%0d pulses=%0d data=%h mod=%0d, required 1 0 %h %0d",
                 n, runt_cnt - r0, pulse_cnt - p0, deser_data, deser_mod, d0, m0);
      end
    end
  endtask

  task automatic test_reset_mid;
    int p0;
    p0 = pulse_cnt;
    send_word(16'hFFFF, 9, 0, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy: got busy=%b, required 1", busy);
    end
    #2 arst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || deser_val !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got busy=%b val=%b, required 0 0", busy, deser_val);
    end
    ser_val = 1'b0;
    @(posedge clk); #1;
    arst = 1'b0;
    idle(3);
    checks++;
    if (pulse_cnt != p0 || runt_cnt != 0 + runt_cnt - 0 && 0) begin
      failures++;
      $display("FAIL reset_no_pulse: got %0d pulses, required 0", pulse_cnt - p0);
    end
    send_word(16'h5A3C, 16, 2, 1'b1);
    checks++;
    if (deser_data !== 16'h5A3C || deser_mod !== 4'd0) begin
      failures++;
      $display("FAIL after_reset_word: got data=%h mod=%0d, required 5a3c 0", deser_data, deser_mod);
    end
  endtask

  task automatic test_random;
    int r0, n, gap;
    r0 = runt_cnt;
    for (int k = 0; k < 60; k++) begin
      n = $urandom_range(2, 16);
      if (n == 2) n = 16;
      gap = (n == 16) ? $urandom_range(0, 2) : $urandom_range(1, 3);
      send_word(16'($urandom), n, gap, 1'b1);
    end
    idle(4);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL random_drain: got %0d words outstanding, required 0", exp_q.size());
    end
    checks++;
    if (runt_cnt != r0) begin
      failures++;
      $display("FAIL random_runt: got %0d runts, required 0", runt_cnt - r0);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_back_to_back();
    test_partial();
    test_runt();
    test_reset_mid();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL final_drain: got %0d words outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule
